// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/funct codes, ALU encodings, mux select codes and FSM states for the multi-cycle controller
package cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps FSM alu_op and R-type funct to the ALU control word
//   alu_op        in  2      00 ADD, 01 SUB, 10 decode funct
//   funct         in  OPW    instr[5:0]
//   alu_control   out ALUCW  ALU operation select
//   illegal_funct out 1      funct unsupported while alu_op requests funct decode
module alu_decoder
    import cpu_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  logic [1:0]       alu_op,
    input  logic [OPW-1:0]   funct,
    output logic [ALUCW-1:0] alu_control,
    output logic             illegal_funct
);
    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        if (alu_op == ALUOP_SUB) begin
            alu_control = ALU_SUB;
        end else if (alu_op == ALUOP_FUNCT) begin
            case (funct)
                F_ADD:   alu_control = ALU_ADD;
                F_SUB:   alu_control = ALU_SUB;
                F_AND:   alu_control = ALU_AND;
                F_OR:    alu_control = ALU_OR;
                F_SLT:   alu_control = ALU_SLT;
                default: illegal_funct = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: instruction-step FSM driving every datapath enable/select of a multi-cycle CPU
//   clk, rst_n                      clock, async active-low reset
//   opcode, funct, zero, mem_ready  instruction fields, ALU zero flag, memory handshake
//   mem_req, mem_write, iord        memory request, store strobe, address select
//   ir_write, reg_write, reg_dst    IR load, register write enable, rt/rd select
//   mem_to_reg, alu_src_a/b         write-back source, ALU operand selects
//   alu_control, pc_src, pc_en      ALU op, PC source select, PC write enable
//   illegal                         one-cycle pulse on unsupported opcode/funct
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic [OPW-1:0]   funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALUCW-1:0] alu_control,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal
);
    state_t     state, next;
    logic [1:0] alu_op;
    logic       illegal_funct;

    alu_decoder #(.OPW(OPW), .ALUCW(ALUCW)) u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (alu_control),
        .illegal_funct (illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= next;
    end

    // Reset clears state asynchronously, so every output (including the
    // mem_ready/zero-qualified ones) drops in the same cycle reset asserts.
    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_src     = PC_ALU;
        pc_en      = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_RESET: next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH;
                case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXECUTE;
                    OP_BEQ:       next = S_BRANCH;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_J:         next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                next    = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = mem_ready;
                next      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                illegal   = illegal_funct;
                next      = illegal_funct ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PC_ALUOUT;
                pc_en     = zero;
                next      = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
                next   = S_FETCH;
            end
            default: next = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector bench for the multi-cycle controller
module tb_multicycle_control;
    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [16:0] ctl;
    int vectors = 0;
    int miscompares = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .illegal(illegal)
    );

    // {mem_req,mem_write,iord,ir_write, reg_write,reg_dst,mem_to_reg,alu_src_a, src_b, alu_control, pc_src, pc_en, illegal}
    assign ctl = {mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_control, pc_src, pc_en, illegal};

    localparam logic [16:0] E_RST   = 17'b0000_0000_00_010_00_0_0;
    localparam logic [16:0] E_FGO   = 17'b1001_0000_01_010_00_1_0;
    localparam logic [16:0] E_FWAIT = 17'b1000_0000_01_010_00_0_0;
    localparam logic [16:0] E_DEC   = 17'b0000_0000_11_010_00_0_0;
    localparam logic [16:0] E_DECIL = 17'b0000_0000_11_010_00_0_1;
    localparam logic [16:0] E_EXADD = 17'b0000_0001_00_010_00_0_0;
    localparam logic [16:0] E_EXSUB = 17'b0000_0001_00_110_00_0_0;
    localparam logic [16:0] E_EXILL = 17'b0000_0001_00_010_00_0_1;
    localparam logic [16:0] E_ALUWB = 17'b0000_1100_00_010_00_0_0;
    localparam logic [16:0] E_MADR  = 17'b0000_0001_10_010_00_0_0;
    localparam logic [16:0] E_MRD   = 17'b1010_0000_00_010_00_0_0;
    localparam logic [16:0] E_MWB   = 17'b0000_1010_00_010_00_0_0;
    localparam logic [16:0] E_MWR   = 17'b1110_0000_00_010_00_0_0;
    localparam logic [16:0] E_BRZ   = 17'b0000_0001_00_110_01_1_0;
    localparam logic [16:0] E_BRNZ  = 17'b0000_0001_00_110_01_0_0;
    localparam logic [16:0] E_ADDIW = 17'b0000_1000_00_010_00_0_0;
    localparam logic [16:0] E_JUMP  = 17'b0000_0000_00_010_10_1_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (ctl !== E_RST) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", ctl, E_RST);
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (ctl !== E_FWAIT) begin
            miscompares++;
            $display("FAIL reset_release_fetch: got %b expected %b", ctl, E_FWAIT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [16:0] seq [5];
        logic        rdy [5];
        seq = '{E_FGO, E_DEC, E_EXADD, E_ALUWB, E_FWAIT};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            vectors++;
            if (ctl !== seq[i]) begin
                miscompares++;
                $display("FAIL add cycle %0d: got %b expected %b", i + 1, ctl, seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] seq [9];
        logic        rdy [9];
        seq = '{E_FGO, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_FWAIT};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            vectors++;
            if (ctl !== seq[i]) begin
                miscompares++;
                $display("FAIL lw_wait cycle %0d: got %b expected %b", i + 1, ctl, seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [16:0] seq [6];
        logic        rdy [6];
        int          writes;
        seq = '{E_FGO, E_DEC, E_MADR, E_MRD, E_MWR, E_FWAIT};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        opcode = 6'b101011;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            writes += int'(mem_write);
            vectors++;
            if (ctl !== seq[i]) begin
                miscompares++;
                $display("FAIL sw cycle %0d: got %b expected %b", i + 1, ctl, seq[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (writes !== 1) begin
            miscompares++;
            $display("FAIL sw_write_count: got %0d expected 1", writes);
        end
    endtask

    task automatic test_beq();
        logic [16:0] seq [4];
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            seq = '{E_FGO, E_DEC, (z == 1) ? E_BRZ : E_BRNZ, E_FWAIT};
            zero = z[0];
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i != 3);
                @(negedge clk);
                vectors++;
                if (ctl !== seq[i]) begin
                    miscompares++;
                    $display("FAIL beq zero=%0d cycle %0d: got %b expected %b", z, i + 1, ctl, seq[i]);
                end
                @(posedge clk); #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal_opcode();
        logic [16:0] seq [3];
        seq = '{E_FGO, E_DECIL, E_FWAIT};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i != 2);
            @(negedge clk);
            vectors++;
            if (ctl !== seq[i]) begin
                miscompares++;
                $display("FAIL illegal_opcode cycle %0d: got %b expected %b", i + 1, ctl, seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_funct();
        logic [16:0] seq [4];
        seq = '{E_FGO, E_DEC, E_EXILL, E_FWAIT};
        opcode = 6'b000000; funct = 6'b000111;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i != 3);
            @(negedge clk);
            vectors++;
            if (ctl !== seq[i]) begin
                miscompares++;
                $display("FAIL illegal_funct cycle %0d: got %b expected %b", i + 1, ctl, seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_jump();
        logic [16:0] seq_a [5];
        logic [16:0] seq_j [4];
        seq_a = '{E_FGO, E_DEC, E_MADR, E_ADDIW, E_FWAIT};
        seq_j = '{E_FGO, E_DEC, E_JUMP, E_FWAIT};
        opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i != 4);
            @(negedge clk);
            vectors++;
            if (ctl !== seq_a[i]) begin
                miscompares++;
                $display("FAIL addi cycle %0d: got %b expected %b", i + 1, ctl, seq_a[i]);
            end
            @(posedge clk); #1;
        end
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i != 3);
            @(negedge clk);
            vectors++;
            if (ctl !== seq_j[i]) begin
                miscompares++;
                $display("FAIL jump cycle %0d: got %b expected %b", i + 1, ctl, seq_j[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] seq [3];
        seq = '{E_FGO, E_DEC, E_EXSUB};
        opcode = 6'b000000; funct = 6'b100010;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (ctl !== seq[i]) begin
                miscompares++;
                $display("FAIL sub cycle %0d: got %b expected %b", i + 1, ctl, seq[i]);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (ctl !== E_RST) begin
            miscompares++;
            $display("FAIL reset_mid_execute: got %b expected %b", ctl, E_RST);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== E_RST) begin
            miscompares++;
            $display("FAIL reset_after_release: got %b expected %b", ctl, E_RST);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (ctl !== E_FWAIT) begin
            miscompares++;
            $display("FAIL fetch_after_reset: got %b expected %b", ctl, E_FWAIT);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_beq();
        test_illegal_opcode();
        test_illegal_funct();
        test_addi_jump();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
